uart_frame_ctrl: RTL and testbench
==================================

UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk, rst.
REQ-002 Parameter CLK_DIV SHALL default to 20834 and set the clk cycles per baud_tick (legal range >= 2).
REQ-003 Parameter FRAME_BYTES SHALL default to 8 and set the bytes per frame, so frame width W = 8*FRAME_BYTES (legal range >= 1).
REQ-004 Parameter FIFO_DEPTH SHALL default to 4 and set the number of frames the FIFO holds (power of two, >= 2).
REQ-005 Parameter TIMEOUT_TICKS SHALL default to 32 and set the number of baud_ticks without a byte after which a partial frame is discarded.
REQ-006 Port list, in this order (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- baud_tick  out  1  one-cycle strobe every CLK_DIV cycles
- rx_byte  in  8  received byte from byte-level UART
- rx_byte_valid  in  1  rx_byte valid, one cycle per byte, no backpressure
- tx_byte  out  8  byte to transmit
- tx_byte_valid  out  1  tx_byte valid
- tx_byte_ready  in  1  byte UART accepts tx_byte
- loopback  in  1  1 = echo received frames; 0 = user-port mode
- frame_out  out  W  FIFO head frame (user mode)
- frame_out_valid  out  1  frame_out valid
- frame_out_ready  in  1  user accepts frame_out
- frame_in  in  W  user frame to transmit
- frame_in_valid  in  1  frame_in valid
- frame_in_ready  out  1  serializer accepts frame_in
- fifo_count  out  clog2(FIFO_DEPTH+1)  frames held in FIFO
- overflow  out  1  sticky: a completed frame was dropped
- frame_err  out  1  sticky: a partial frame timed out

Function
REQ-007 Tick counter SHALL count 0..CLK_DIV-1 and wrap; baud_tick SHALL be high only in the cycle the count equals CLK_DIV-1.
REQ-008 Assembler SHALL pack bytes MSB-first: the first byte of a frame lands in bits [W-1:W-8] and the last byte in [7:0].
REQ-009 When the FRAME_BYTES-th byte is accepted at cycle T, the frame SHALL be written to the FIFO at the T edge and the byte index SHALL clear; fifo_count and frame_out_valid SHALL reflect the write from T+1.
REQ-010 If the FIFO is full at completion and no pop occurs in the same cycle, the frame SHALL be dropped and overflow set; a simultaneous pop SHALL allow the push.
REQ-011 While the byte index is nonzero, a timeout counter SHALL count baud_ticks and clear on each rx_byte_valid; on reaching TIMEOUT_TICKS it SHALL clear the index, discard the partial frame and set frame_err.
REQ-012 rx_byte_valid arriving in the same cycle as a timeout SHALL be taken as byte 0 of a new frame.
REQ-013 The FIFO SHALL be first-word-fall-through; frame_out SHALL be the head frame whenever fifo_count > 0.
REQ-014 frame_out_valid SHALL equal (fifo_count > 0) AND NOT loopback; a pop SHALL occur on frame_out_valid AND frame_out_ready.
REQ-015 The serializer state machine SHALL have states IDLE and SEND.
REQ-016 IDLE -> SEND, loopback = 1: when the FIFO is nonempty, the serializer SHALL pop the head into its shift register.
REQ-017 IDLE -> SEND, loopback = 0: when frame_in_valid is high, the serializer SHALL load frame_in; frame_in_ready SHALL be high only in IDLE with loopback = 0.
REQ-018 In SEND, tx_byte SHALL be the top byte of the shift register and tx_byte_valid SHALL be high; on tx_byte_ready the register SHALL shift left 8 bits, and after the FRAME_BYTES-th handshake the state SHALL return to IDLE.
REQ-019 tx_byte and tx_byte_valid SHALL stay stable while tx_byte_ready is low.
REQ-020 loopback SHALL be sampled only at the IDLE load decision; a change during SEND SHALL take effect for the next frame.
REQ-021 In loopback mode the FIFO SHALL not be popped through the user port; in user mode the serializer SHALL not read the FIFO.
REQ-022 Idle-to-first-byte latency in loopback mode SHALL be 2 cycles: last rx byte at T, tx_byte_valid high at T+2.
REQ-023 overflow and frame_err SHALL be cleared only by reset.

Reset
REQ-024 With rst high at a clk edge, the block SHALL clear the tick counter, byte index, timeout counter, FIFO pointers, fifo_count, overflow and frame_err, and return the serializer to IDLE.
REQ-025 In the cycle after reset, baud_tick, tx_byte_valid and frame_out_valid SHALL be 0, and tx_byte and frame_out SHALL be 0.
REQ-026 Reset during SEND or mid-frame SHALL abandon the frame with no further tx_byte_valid.

Verification
REQ-027 CLK_DIV=4: release reset -> baud_tick high at cycles 3, 7, 11 after release.
REQ-028 loopback=1, FRAME_BYTES=8, bytes 0x01..0x08, tx_byte_ready=1 -> tx_byte sequence 0x01..0x08, first byte 2 cycles after the last rx byte.
REQ-029 loopback=0, FIFO_DEPTH=4, five frames received, frame_out_ready=0 -> fifo_count=4, overflow=1, and draining returns frames 1-4 in order.
REQ-030 Three bytes, then no bytes for TIMEOUT_TICKS baud_ticks -> frame_err=1, byte index 0, and the next 8 bytes form a correct frame.
REQ-031 loopback=0, frame_in=0xAABBCCDD11223344, tx_byte_ready toggling -> bytes AA,BB,CC,DD,11,22,33,44 with tx_byte stable while ready is low.
REQ-032 rst asserted during byte 4 of SEND -> tx_byte_valid=0 the next cycle and fifo_count=0.

Source files
------------

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl
//   Frame layer on top of a byte-level UART. Received bytes are packed MSB-first
//   into FRAME_BYTES-wide frames and queued in a first-word-fall-through FIFO. A
//   serializer sends frames out byte by byte. The frames come either from the
//   FIFO (loopback echo) or from the user port. Partial frames are discarded
//   after TIMEOUT_TICKS idle baud ticks.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   baud_tick                 one-cycle strobe every CLK_DIV cycles
//   rx_byte/rx_byte_valid     incoming bytes, no backpressure
//   tx_byte/_valid/_ready     outgoing bytes, valid/ready handshake
//   loopback                  1 = echo FIFO frames, 0 = user-port mode
//   frame_out/_valid/_ready   FIFO head towards the user (user mode only)
//   frame_in/_valid/_ready    user frame to transmit (user mode only)
//   fifo_count                frames currently held in the FIFO
//   overflow, frame_err       sticky flags, cleared only by rst
module uart_frame_ctrl #(
    parameter int CLK_DIV       = 20834,
    parameter int FRAME_BYTES   = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int TIMEOUT_TICKS = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic                              baud_tick,
    input  logic [7:0]                        rx_byte,
    input  logic                              rx_byte_valid,
    output logic [7:0]                        tx_byte,
    output logic                              tx_byte_valid,
    input  logic                              tx_byte_ready,
    input  logic                              loopback,
    output logic [8*FRAME_BYTES-1:0]          frame_out,
    output logic                              frame_out_valid,
    input  logic                              frame_out_ready,
    input  logic [8*FRAME_BYTES-1:0]          frame_in,
    input  logic                              frame_in_valid,
    output logic                              frame_in_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              overflow,
    output logic                              frame_err
);

    localparam int W  = 8 * FRAME_BYTES;
    localparam int TW = $clog2(CLK_DIV);
    localparam int BW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int OW = $clog2(TIMEOUT_TICKS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(FRAME_BYTES - 1);
    localparam logic [OW-1:0] TO_LAST   = OW'(TIMEOUT_TICKS - 1);
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    logic [TW-1:0] tick_cnt_r;
    logic [BW-1:0] byte_idx_r;
    logic [W-1:0]  acc_r;
    logic [OW-1:0] to_cnt_r;
    logic          frame_err_r;
    logic [W-1:0]  acc_next_s;
    logic          timeout_s;
    logic          complete_s;

    logic [W-1:0]  fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] fifo_cnt_r;
    logic          overflow_r;
    logic          empty_s;
    logic          full_s;
    logic          user_pop_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    logic [W-1:0]  frame_head_s;

    state_t        state_r;
    state_t        state_next_s;
    logic [W-1:0]  shift_r;
    logic [BW-1:0] sent_cnt_r;
    logic          ser_pop_s;
    logic          user_load_s;
    logic          frame_in_ready_s;
    logic          tx_valid_s;
    logic          last_byte_s;

    // Baud tick divider: free-running 0..CLK_DIV-1
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_r <= '0;
        end else if (tick_cnt_r == TICK_LAST) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
        end
    end

    assign baud_tick = (tick_cnt_r == TICK_LAST);

    // Assembler decode: next packed value, timeout event, frame completion
    always_comb begin
        acc_next_s = W'(acc_r << 8) | W'(rx_byte);
        timeout_s  = (byte_idx_r != '0) && baud_tick && (to_cnt_r == TO_LAST);
        // A byte arriving with the timeout starts a new frame, so it never completes the old one
        complete_s = rx_byte_valid && !timeout_s && (byte_idx_r == BYTE_LAST);
    end

    // Assembler state: byte index, partial frame, idle-tick timeout, frame_err flag
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx_r  <= '0;
            acc_r       <= '0;
            to_cnt_r    <= '0;
            frame_err_r <= 1'b0;
        end else if (timeout_s) begin
            frame_err_r <= 1'b1;
            to_cnt_r    <= '0;
            if (rx_byte_valid) begin
                byte_idx_r <= BW'(1);
                acc_r      <= W'(rx_byte);
            end else begin
                byte_idx_r <= '0;
                acc_r      <= '0;
            end
        end else if (rx_byte_valid) begin
            to_cnt_r <= '0;
            if (byte_idx_r == BYTE_LAST) begin
                byte_idx_r <= '0;
                acc_r      <= '0;
            end else begin
                byte_idx_r <= byte_idx_r + BW'(1);
                acc_r      <= acc_next_s;
            end
        end else if ((byte_idx_r != '0) && baud_tick) begin
            to_cnt_r <= to_cnt_r + OW'(1);
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    // FIFO handshake decode; a same-cycle pop frees room for a push into a full FIFO
    always_comb begin
        empty_s      = (fifo_cnt_r == '0);
        full_s       = (fifo_cnt_r == FIFO_FULL);
        frame_head_s = fifo_mem_r[rd_ptr_r];
        user_pop_s   = !empty_s && !loopback && frame_out_ready;
        pop_s        = user_pop_s || ser_pop_s;
        push_s       = complete_s && (!full_s || pop_s);
        drop_s       = complete_s && full_s && !pop_s;
    end

    // FIFO storage: written with the completed frame in its completion cycle
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= acc_next_s;
        end
    end

    // FIFO pointers, occupancy and overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_cnt_r <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CW'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CW'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    // Serializer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Serializer next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (ser_pop_s || user_load_s) begin
                    state_next_s = SEND;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SEND: begin
                if (tx_byte_ready && last_byte_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = SEND;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Serializer outputs; loopback is only looked at in IDLE, when the next frame is chosen
    always_comb begin
        tx_valid_s       = 1'b0;
        frame_in_ready_s = 1'b0;
        ser_pop_s        = 1'b0;
        user_load_s      = 1'b0;
        last_byte_s      = (sent_cnt_r == BYTE_LAST);
        case (state_r)
            IDLE: begin
                if (loopback) begin
                    ser_pop_s = !empty_s;
                end else begin
                    frame_in_ready_s = 1'b1;
                    user_load_s      = frame_in_valid;
                end
            end
            SEND:    tx_valid_s = 1'b1;
            default: tx_valid_s = 1'b0;
        endcase
    end

    // Serializer datapath: load a frame, then shift one byte out per accepted handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r    <= '0;
            sent_cnt_r <= '0;
        end else if (ser_pop_s) begin
            shift_r    <= frame_head_s;
            sent_cnt_r <= '0;
        end else if (user_load_s) begin
            shift_r    <= frame_in;
            sent_cnt_r <= '0;
        end else if ((state_r == SEND) && tx_byte_ready) begin
            shift_r    <= W'(shift_r << 8);
            sent_cnt_r <= last_byte_s ? '0 : (sent_cnt_r + BW'(1));
        end else begin
            shift_r    <= shift_r;
            sent_cnt_r <= sent_cnt_r;
        end
    end

    // Output drive; frame_out reads as zero while the FIFO is empty
    always_comb begin
        frame_out       = empty_s ? '0 : frame_head_s;
        frame_out_valid = !empty_s && !loopback;
        tx_byte         = shift_r[W-1 -: 8];
        tx_byte_valid   = tx_valid_s;
        frame_in_ready  = frame_in_ready_s;
        fifo_count      = fifo_cnt_r;
        overflow        = overflow_r;
        frame_err       = frame_err_r;
    end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
module tb_uart_frame_ctrl;

    localparam int CLK_DIV       = 4;
    localparam int FRAME_BYTES   = 8;
    localparam int FIFO_DEPTH    = 4;
    localparam int TIMEOUT_TICKS = 4;
    localparam int W             = 8 * FRAME_BYTES;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          baud_tick;
    logic [7:0]    rx_byte = 8'h00;
    logic          rx_byte_valid = 1'b0;
    logic [7:0]    tx_byte;
    logic          tx_byte_valid;
    logic          tx_byte_ready = 1'b0;
    logic          loopback = 1'b0;
    logic [W-1:0]  frame_out;
    logic          frame_out_valid;
    logic          frame_out_ready = 1'b0;
    logic [W-1:0]  frame_in = '0;
    logic          frame_in_valid = 1'b0;
    logic          frame_in_ready;
    logic [2:0]    fifo_count;
    logic          overflow;
    logic          frame_err;

    logic [7:0]    exp_tx_q[$];
    logic [W-1:0]  exp_frame_q[$];
    int            tests_run = 0;
    int            tests_failed = 0;
    bit            mon_en = 1'b0;
    logic          prev_hold = 1'b0;
    logic [7:0]    prev_byte = 8'h00;

    uart_frame_ctrl #(
        .CLK_DIV(CLK_DIV),
        .FRAME_BYTES(FRAME_BYTES),
        .FIFO_DEPTH(FIFO_DEPTH),
        .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .baud_tick(baud_tick),
        .rx_byte(rx_byte),
        .rx_byte_valid(rx_byte_valid),
        .tx_byte(tx_byte),
        .tx_byte_valid(tx_byte_valid),
        .tx_byte_ready(tx_byte_ready),
        .loopback(loopback),
        .frame_out(frame_out),
        .frame_out_valid(frame_out_valid),
        .frame_out_ready(frame_out_ready),
        .frame_in(frame_in),
        .frame_in_valid(frame_in_valid),
        .frame_in_ready(frame_in_ready),
        .fifo_count(fifo_count),
        .overflow(overflow),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte       = b;
        rx_byte_valid = 1'b1;
        cycle();
        rx_byte_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] f);
        for (int i = 0; i < FRAME_BYTES; i++) begin
            send_byte(f[W-1-8*i -: 8]);
        end
    endtask

    task automatic wait_tx_drain(input int bound);
        int n;
        n = 0;
        while (exp_tx_q.size() != 0 && n < bound) begin
            cycle();
            n++;
        end
        check("tx_drain", exp_tx_q.size(), 0);
        repeat (2) cycle();
    endtask

    // Byte scoreboard plus hold-stability check on the transmit side
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_hold) begin
                check("tx_hold_valid", tx_byte_valid, 1);
                check("tx_hold_byte", tx_byte, prev_byte);
            end
            if (tx_byte_valid && tx_byte_ready) begin
                check("tx_expected", exp_tx_q.size() != 0, 1);
                if (exp_tx_q.size() != 0) begin
                    check("tx_byte", tx_byte, exp_tx_q.pop_front());
                end
            end
            prev_hold = tx_byte_valid && !tx_byte_ready;
            prev_byte = tx_byte;
        end else begin
            prev_hold = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0]  tick_vec;
        logic [W-1:0] f;
        int           n;

        // Reset values and baud tick spacing
        do_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("rst_baud_tick", baud_tick, 0);
                check("rst_tx_valid", tx_byte_valid, 0);
                check("rst_fo_valid", frame_out_valid, 0);
                check("rst_tx_byte", tx_byte, 0);
                check("rst_frame_out", frame_out, 0);
                check("rst_fifo_count", fifo_count, 0);
                check("rst_flags", {overflow, frame_err}, 0);
            end
            tick_vec[i] = baud_tick;
            cycle();
        end
        check("baud_tick_pattern", tick_vec, 12'h888);
        mon_en = 1'b1;

        // Loopback echo of bytes 01..08 with 2-cycle latency
        loopback      = 1'b1;
        tx_byte_ready = 1'b1;
        for (int b = 1; b <= 8; b++) exp_tx_q.push_back(8'(b));
        for (int b = 1; b <= 8; b++) send_byte(8'(b));
        @(negedge clk);
        check("lb_lat_t1", tx_byte_valid, 0);
        cycle();
        @(negedge clk);
        check("lb_lat_t2", tx_byte_valid, 1);
        wait_tx_drain(40);
        check("lb_fifo_empty", fifo_count, 0);
        check("lb_idle", tx_byte_valid, 0);

        // Overflow: five frames into a four-deep FIFO, then drain in order
        loopback = 1'b0;
        do_reset();
        frame_out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            f = {$urandom, $urandom};
            if (k < 4) exp_frame_q.push_back(f);
            send_frame(f);
            if (k == 3) begin
                check("ovf_count4", fifo_count, 4);
                check("ovf_not_yet", overflow, 0);
            end
        end
        check("ovf_count_full", fifo_count, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_fo_valid", frame_out_valid, 1);
        frame_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("drain_frame", frame_out, exp_frame_q.pop_front());
            cycle();
        end
        frame_out_ready = 1'b0;
        check("drain_count", fifo_count, 0);
        check("drain_fo_valid", frame_out_valid, 0);
        check("drain_frame_zero", frame_out, 0);
        check("ovf_sticky", overflow, 1);

        // Partial-frame timeout, then a clean frame
        do_reset();
        send_byte(8'hA1);
        send_byte(8'hA2);
        send_byte(8'hA3);
        repeat (2) cycle();
        check("to_not_early", frame_err, 0);
        n = 0;
        while (!frame_err && n < 60) begin
            cycle();
            n++;
        end
        check("to_frame_err", frame_err, 1);
        check("to_fifo_empty", fifo_count, 0);
        f = {$urandom, $urandom};
        exp_frame_q.push_back(f);
        send_frame(f);
        check("to_next_count", fifo_count, 1);
        check("to_next_frame", frame_out, exp_frame_q.pop_front());
        frame_out_ready = 1'b1;
        cycle();
        frame_out_ready = 1'b0;

        // User frame transmit with toggling tx_byte_ready
        do_reset();
        tx_byte_ready = 1'b0;
        f = 64'hAABBCCDD11223344;
        for (int i = 0; i < FRAME_BYTES; i++) exp_tx_q.push_back(f[W-1-8*i -: 8]);
        frame_in       = f;
        frame_in_valid = 1'b1;
        check("fin_ready_idle", frame_in_ready, 1);
        cycle();
        frame_in_valid = 1'b0;
        check("fin_ready_send", frame_in_ready, 0);
        check("fin_first_byte", tx_byte, 8'hAA);
        n = 0;
        while (exp_tx_q.size() != 0 && n < 100) begin
            tx_byte_ready = ~tx_byte_ready;
            cycle();
            n++;
        end
        check("fin_drain", exp_tx_q.size(), 0);
        tx_byte_ready = 1'b1;
        repeat (2) cycle();
        check("fin_idle", tx_byte_valid, 0);

        // Reset in the middle of a loopback frame
        do_reset();
        mon_en        = 1'b0;
        loopback      = 1'b1;
        tx_byte_ready = 1'b1;
        send_frame(64'h1122334455667788);
        repeat (4) cycle();
        check("mid_valid", tx_byte_valid, 1);
        check("mid_byte4", tx_byte, 8'h44);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mid_rst_valid", tx_byte_valid, 0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_byte", tx_byte, 0);
        repeat (5) cycle();
        check("mid_rst_quiet", tx_byte_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
